// File: rtl/if_fetch.sv
// Instruction fetch stage: keeps up to two requests in flight and queues
// fetched words ahead of decode, with stall, redirect and stale-response kill.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   stall_i             hold the instruction presented to decode
//   jump_flag_i/addr_i  redirect from execute (priority over stall)
//   imem_req_o/addr_o   fetch request, held stable until imem_gnt_i
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i/rdata_i  in-order response
//   inst_o/inst_addr_o/inst_valid_o  registered instruction to decode
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;
    // Back-to-back redirects can stack killed responses beyond two; the
    // in-flight cap below bounds this counter to 0..4.
    logic [2:0]  kill_q, kill_d;

    logic [31:0] af_q [2];
    logic        af_wp_q, af_wp_d;
    logic        af_rp_q, af_rp_d;
    logic        af_we;

    logic [31:0] iq_inst_q [2];
    logic [31:0] iq_pc_q [2];
    logic        iq_wp_q, iq_wp_d;
    logic        iq_rp_q, iq_rp_d;
    logic [1:0]  iq_cnt_q, iq_cnt_d;
    logic        iq_we;

    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        inst_valid_q, inst_valid_d;

    logic        credit_ok;
    logic [3:0]  inflight;
    logic        req;
    logic        fire;
    logic        rsp_take;
    logic        rsp_kill;
    logic [31:0] rsp_pc;
    logic        push;
    logic        pop;
    logic        unused;

    assign unused = ^jump_addr_i[1:0];

    always_comb begin
        credit_ok = ({1'b0, out_q} + {1'b0, iq_cnt_q}) < 3'd2;
        // Total responses still owed by memory, live or to be discarded.
        inflight  = {1'b0, kill_q} + {2'b00, out_q};
        req       = !rst_i && !jump_flag_i && credit_ok
                    && (inflight < 4'd4);
        fire      = req && imem_gnt_i;
        rsp_take  = imem_rvalid_i && (kill_q == 3'd0);
        rsp_kill  = imem_rvalid_i && (kill_q != 3'd0);
        rsp_pc    = af_q[af_rp_q];
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;

    always_comb begin
        pc_d         = pc_q;
        out_d        = out_q;
        kill_d       = kill_q;
        af_wp_d      = af_wp_q;
        af_rp_d      = af_rp_q;
        af_we        = 1'b0;
        iq_wp_d      = iq_wp_q;
        iq_rp_d      = iq_rp_q;
        iq_cnt_d     = iq_cnt_q;
        iq_we        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;

        if (jump_flag_i) begin
            pc_d         = {jump_addr_i[31:2], 2'b00};
            out_d        = 2'd0;
            // A response landing now retires one owed response (live or
            // already killed) and is dropped with the flush.
            kill_d       = kill_q + {1'b0, out_q}
                           - {2'b00, imem_rvalid_i};
            af_wp_d      = 1'b0;
            af_rp_d      = 1'b0;
            iq_wp_d      = 1'b0;
            iq_rp_d      = 1'b0;
            iq_cnt_d     = 2'd0;
            inst_d       = NOP_INST;
            inst_addr_d  = 32'd0;
            inst_valid_d = 1'b0;
        end else begin
            if (fire) begin
                pc_d    = pc_q + 32'd4;
                af_we   = 1'b1;
                af_wp_d = ~af_wp_q;
            end
            if (rsp_kill) begin
                kill_d = kill_q - 3'd1;
            end
            if (rsp_take) begin
                af_rp_d = ~af_rp_q;
            end
            out_d = out_q + {1'b0, fire} - {1'b0, rsp_take};

            // An arriving word bypasses the queue when it is empty and
            // decode is ready; this gives 1 inst/cycle with one in flight.
            push = rsp_take && (stall_i || (iq_cnt_q != 2'd0));
            pop  = !stall_i && (iq_cnt_q != 2'd0);

            if (!stall_i) begin
                if (pop) begin
                    inst_d       = iq_inst_q[iq_rp_q];
                    inst_addr_d  = iq_pc_q[iq_rp_q];
                    inst_valid_d = 1'b1;
                end else if (rsp_take) begin
                    inst_d       = imem_rdata_i;
                    inst_addr_d  = rsp_pc;
                    inst_valid_d = 1'b1;
                end else begin
                    inst_d       = NOP_INST;
                    inst_addr_d  = 32'd0;
                    inst_valid_d = 1'b0;
                end
            end

            if (push) begin
                iq_we   = 1'b1;
                iq_wp_d = ~iq_wp_q;
            end
            if (pop) begin
                iq_rp_d = ~iq_rp_q;
            end
            iq_cnt_d = iq_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            out_q        <= 2'd0;
            kill_q       <= 3'd0;
            af_wp_q      <= 1'b0;
            af_rp_q      <= 1'b0;
            iq_wp_q      <= 1'b0;
            iq_rp_q      <= 1'b0;
            iq_cnt_q     <= 2'd0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= 32'd0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            out_q        <= out_d;
            kill_q       <= kill_d;
            af_wp_q      <= af_wp_d;
            af_rp_q      <= af_rp_d;
            iq_wp_q      <= iq_wp_d;
            iq_rp_q      <= iq_rp_d;
            iq_cnt_q     <= iq_cnt_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Storage arrays need no reset: pointers and counts gate every read.
    always_ff @(posedge clk_i) begin
        if (af_we && !rst_i) begin
            af_q[af_wp_q] <= pc_q;
        end
        if (iq_we && !rst_i) begin
            iq_inst_q[iq_wp_q] <= imem_rdata_i;
            iq_pc_q[iq_wp_q]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic against an
// in-order memory, checked each cycle against a queue-level model.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    int checks = 0;
    int errors = 0;

    // memory side: addresses granted and not yet answered
    logic [31:0] mq [$];

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_live [$];
    int          m_dead;
    logic [31:0] m_iq [$];
    bit          m_ov;
    logic [31:0] m_oa;

    if_fetch dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle; entered and left at the falling edge.
    task automatic step(input bit r, input bit st, input bit j,
                        input logic [31:0] ja, input int gp,
                        input int rp);
        bit          exp_req;
        bit          have;
        logic [31:0] a;
        rst_i       = r;
        stall_i     = st;
        jump_flag_i = j;
        jump_addr_i = ja;
        imem_gnt_i  = ($urandom_range(99) < gp);
        if (mq.size() > 0 && $urandom_range(99) < rp) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memw(mq[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        exp_req = !r && !j && (m_live.size() + m_iq.size() < 2)
                  && (m_live.size() + m_dead < 4);
        chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (exp_req) chk("addr", imem_addr_o, m_pc);

        // model next state
        if (r) begin
            m_pc = 32'h0;
            m_live.delete();
            m_iq.delete();
            m_dead = 0;
            m_ov = 0;
            m_oa = 0;
        end else if (j) begin
            m_dead = m_dead + m_live.size() - (imem_rvalid_i ? 1 : 0);
            m_live.delete();
            m_iq.delete();
            m_pc = {ja[31:2], 2'b00};
            m_ov = 0;
            m_oa = 0;
        end else begin
            have = 0;
            a = 0;
            if (imem_rvalid_i) begin
                if (m_dead > 0) m_dead--;
                else if (m_live.size() > 0) begin
                    a = m_live.pop_front();
                    have = 1;
                end
            end
            if (exp_req && imem_gnt_i) begin
                m_live.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (have) m_iq.push_back(a);
            if (!st) begin
                if (m_iq.size() > 0) begin
                    m_ov = 1;
                    m_oa = m_iq.pop_front();
                end else begin
                    m_ov = 0;
                    m_oa = 0;
                end
            end
        end

        // memory bookkeeping follows what the DUT actually did
        if (r) mq.delete();
        else begin
            if (imem_rvalid_i) void'(mq.pop_front());
            if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
        end

        @(posedge clk_i);
        @(negedge clk_i);
        chk("valid", {31'd0, inst_valid_o}, {31'd0, m_ov});
        chk("iaddr", inst_addr_o, m_oa);
        chk("inst", inst_o, m_ov ? memw(m_oa) : NOP);
    endtask

    initial begin
        int n;
        rst_i = 1; stall_i = 0; jump_flag_i = 0; jump_addr_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        m_pc = 0; m_dead = 0; m_ov = 0; m_oa = 0;
        @(negedge clk_i);

        step(1, 0, 0, 0, 100, 100);
        step(1, 0, 0, 0, 100, 100);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, NOP);

        step(0, 0, 0, 0, 100, 100);
        step(0, 0, 0, 0, 100, 100);
        chk("first_inst", inst_o, 32'h0050_0093);
        chk("first_pc", inst_addr_o, 32'h0);
        step(0, 0, 0, 0, 100, 100);
        step(0, 0, 0, 0, 100, 100);
        chk("at8", inst_addr_o, 32'h8);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 100, 100);
            chk("stall_hold", inst_addr_o, 32'h8);
        end
        chk("stall_noreq", {31'd0, imem_req_o}, 32'd0);
        step(0, 0, 0, 0, 100, 100);
        chk("rel12", inst_addr_o, 32'hC);
        step(0, 0, 0, 0, 100, 100);
        chk("rel16", inst_addr_o, 32'h10);
        step(0, 0, 0, 0, 100, 100);
        chk("rel20", inst_addr_o, 32'h14);

        step(0, 0, 0, 0, 100, 0);
        step(0, 0, 0, 0, 100, 0);
        step(0, 0, 1, 32'h0000_0102, 100, 0);
        chk("jump_pc", imem_addr_o, 32'h100);
        n = 0;
        do begin
            step(0, 0, 0, 0, 100, 100);
            n++;
        end while (!inst_valid_o && n < 20);
        chk("jump_first", inst_addr_o, 32'h100);

        step(0, 1, 1, 32'h40, 100, 100);
        chk("js_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("js_pc", imem_addr_o, 32'h40);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 100);
            chk("nogrant_req", {31'd0, imem_req_o}, 32'd1);
            chk("nogrant_addr", imem_addr_o, 32'h40);
        end

        step(0, 0, 1, 32'hFFFF_FFFC, 100, 100);
        step(0, 0, 0, 0, 100, 100);
        chk("wrap", imem_addr_o, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 1, $urandom_range(99) < 30,
                 $urandom_range(99) < 5, $urandom,
                 $urandom_range(40, 100), $urandom_range(30, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
